// File: rtl/afifo_rd_pkg.sv
// ---------------------------------------------------------------------------
// afifo_rd_pkg
// Shared types for the async_fifo read-side stream consumer.
//   state_t    : consumer FSM states (IDLE, RUN)
//   occ_t      : skid buffer occupancy (0..2)
//   pidx_width : width of the packet word index for a given packet length
// ---------------------------------------------------------------------------
package afifo_rd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_FULL = 2'd2;

    // A packet length of 1 still needs a 1-bit index so the counter
    // declaration stays legal; the index simply never moves off zero.
    function automatic int pidx_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/afifo_rd_skid.sv
// ---------------------------------------------------------------------------
// afifo_rd_skid
// Two-entry, first-in-first-out {data, last} buffer between the FIFO pop
// strobe and the outgoing valid/ready stream. The head entry drives the
// stream outputs straight from registers.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   push                 write in_data/in_last this cycle
//   in_data, in_last     word and its end-of-packet tag
//   occ                  number of buffered entries (0..2)
//   out_valid            head entry present
//   out_ready            consumer takes the head entry
//   out_data, out_last   head entry contents
// ---------------------------------------------------------------------------
module afifo_rd_skid
    import afifo_rd_pkg::*;
#(
    parameter int DSIZE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_last,
    output logic [1:0]       occ,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic             out_last
);

    occ_t             count;
    occ_t             count_next;
    logic [DSIZE-1:0] head_data;
    logic [DSIZE-1:0] tail_data;
    logic             head_last;
    logic             tail_last;
    logic             pop;
    logic             push_ok;

    // A push into a full buffer is only accepted when the head leaves in the
    // same cycle; the occupancy moves by at most one either way.
    always_comb begin
        pop        = (count != 2'd0) && out_ready;
        push_ok    = push && ((count != OCC_FULL) || pop);
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + 2'd1;
        end else if (!push_ok && pop) begin
            count_next = count - 2'd1;
        end
    end

    // The head register always holds the oldest word. It reloads from the
    // tail when a full buffer drains, or from the input when the new word
    // would otherwise land in an empty head slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            count <= count_next;
            if (pop && (count == OCC_FULL)) begin
                head_data <= tail_data;
                head_last <= tail_last;
            end else if (push_ok && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                head_data <= in_data;
                head_last <= in_last;
            end
            if (push_ok && (((count == 2'd1) && !pop) || ((count == OCC_FULL) && pop))) begin
                tail_data <= in_data;
                tail_last <= in_last;
            end
        end
    end

    assign occ       = count;
    assign out_valid = (count != 2'd0);
    assign out_data  = head_data;
    assign out_last  = head_last;

endmodule

// File: rtl/afifo_rd_stream.sv
// ---------------------------------------------------------------------------
// afifo_rd_stream
// Read-domain consumer for async_fifo. Pops the first-word-fall-through FIFO
// into a two-entry skid buffer and presents the words as a valid/ready
// stream with m_last marking every PKT_LEN-th word. Counts delivered words
// and packets.
// Ports:
//   rclk, rrst          read clock, synchronous active-high reset
//   en                  allow starting / continuing packets
//   rinc                FIFO pop strobe
//   rdata, rempty       FIFO head word and empty flag
//   arempty             FIFO holds at most one word
//   m_data, m_valid,
//   m_ready, m_last     outgoing stream
//   word_cnt, pkt_cnt   delivered words / packets, wrapping
// ---------------------------------------------------------------------------
module afifo_rd_stream
    import afifo_rd_pkg::*;
#(
    parameter int DSIZE      = 32,
    parameter int PKT_LEN    = 16,
    parameter int WAIT_BURST = 0,
    parameter int CNT_W      = 32
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             en,
    output logic             rinc,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    input  logic             arempty,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam int PIDX_W = pidx_width(PKT_LEN);
    typedef logic [PIDX_W-1:0] pidx_t;
    localparam pidx_t LAST_IDX = pidx_t'(PKT_LEN - 1);

    state_t state;
    pidx_t  pop_idx;
    occ_t   occ;
    logic   at_last;
    logic   start_ok;
    logic   handshake;

    // Pops come from registered state and occupancy plus the live empty
    // flag, so rinc can never fire against an empty FIFO.
    always_comb begin
        at_last   = (pop_idx == LAST_IDX);
        start_ok  = en && !rempty && ((WAIT_BURST == 0) || !arempty);
        rinc      = !rrst && (state == RUN) && !rempty && (occ != OCC_FULL);
        handshake = m_valid && m_ready;
    end

    // IDLE is only entered on a packet boundary. When en is low the FSM
    // leaves RUN on the same edge that pops the packet's last word, so the
    // first word of the next packet is never popped; at an already-reached
    // boundary a pop in that cycle starts a packet which must then finish.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state   <= IDLE;
            pop_idx <= '0;
        end else begin
            if (rinc) begin
                pop_idx <= at_last ? '0 : pop_idx + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en && ((rinc && at_last) || (!rinc && (pop_idx == '0)))) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delivered-word and delivered-packet counters wrap naturally.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            word_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (handshake) begin
            word_cnt <= word_cnt + 1'b1;
            if (m_last) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

    afifo_rd_skid #(
        .DSIZE (DSIZE)
    ) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .push      (rinc),
        .in_data   (rdata),
        .in_last   (at_last),
        .occ       (occ),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .out_last  (m_last)
    );

endmodule

// File: tb/tb_afifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_afifo_rd_stream
// Three consumer instances (PKT_LEN=16, PKT_LEN=16 with WAIT_BURST=1,
// PKT_LEN=1) share one behavioural FIFO; only the selected instance is out
// of reset at any time. Words written to the FIFO are also pushed to an
// expected-output queue tagged with their end-of-packet flag.
// ---------------------------------------------------------------------------
module tb_afifo_rd_stream;

    localparam int DW = 32;
    localparam int CW = 32;

    logic             rclk = 1'b0;
    logic [2:0]       rrst_v;
    logic             en;
    logic             m_ready;
    logic [DW-1:0]    rdata;
    logic             rempty;
    logic             arempty;
    logic [2:0]       rinc_v;
    logic [2:0]       m_valid_v;
    logic [2:0]       m_last_v;
    logic [DW-1:0]    m_data_v   [3];
    logic [CW-1:0]    word_cnt_v [3];
    logic [CW-1:0]    pkt_cnt_v  [3];

    logic [1:0]       sel;
    logic             rinc_s;
    logic             m_valid_s;
    logic             m_last_s;
    logic [DW-1:0]    m_data_s;
    logic [CW-1:0]    word_cnt_s;
    logic [CW-1:0]    pkt_cnt_s;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        logic [1:0]    sel;
        int            nwords;
        bit            toggle;
        logic [DW-1:0] base;
        int            exp_words;
        int            exp_pkts;
        bit            check_rate;
    } vec_t;

    logic [DW-1:0] fifo_q[$];
    exp_t          exp_q[$];
    vec_t          vecs[5];

    int            vectors    = 0;
    int            miscompares = 0;
    int            cur_len;
    int            exp_idx;
    int            rinc_cnt;
    int            cyc;
    int            first_hs;
    int            last_hs;
    bit            toggle;
    bit            prev_stall;
    bit            hs_seen;
    logic [DW-1:0] hs_data;

    always #5 rclk = ~rclk;

    afifo_rd_stream #(.DSIZE(DW), .PKT_LEN(16), .WAIT_BURST(0), .CNT_W(CW)) u_dut0 (
        .rclk(rclk), .rrst(rrst_v[0]), .en(en), .rinc(rinc_v[0]), .rdata(rdata),
        .rempty(rempty), .arempty(arempty), .m_data(m_data_v[0]), .m_valid(m_valid_v[0]),
        .m_ready(m_ready), .m_last(m_last_v[0]), .word_cnt(word_cnt_v[0]), .pkt_cnt(pkt_cnt_v[0])
    );

    afifo_rd_stream #(.DSIZE(DW), .PKT_LEN(16), .WAIT_BURST(1), .CNT_W(CW)) u_dut1 (
        .rclk(rclk), .rrst(rrst_v[1]), .en(en), .rinc(rinc_v[1]), .rdata(rdata),
        .rempty(rempty), .arempty(arempty), .m_data(m_data_v[1]), .m_valid(m_valid_v[1]),
        .m_ready(m_ready), .m_last(m_last_v[1]), .word_cnt(word_cnt_v[1]), .pkt_cnt(pkt_cnt_v[1])
    );

    afifo_rd_stream #(.DSIZE(DW), .PKT_LEN(1), .WAIT_BURST(0), .CNT_W(CW)) u_dut2 (
        .rclk(rclk), .rrst(rrst_v[2]), .en(en), .rinc(rinc_v[2]), .rdata(rdata),
        .rempty(rempty), .arempty(arempty), .m_data(m_data_v[2]), .m_valid(m_valid_v[2]),
        .m_ready(m_ready), .m_last(m_last_v[2]), .word_cnt(word_cnt_v[2]), .pkt_cnt(pkt_cnt_v[2])
    );

    // Route the selected instance's outputs to the checking logic.
    always_comb begin
        rinc_s     = rinc_v[sel];
        m_valid_s  = m_valid_v[sel];
        m_last_s   = m_last_v[sel];
        m_data_s   = m_data_v[sel];
        word_cnt_s = word_cnt_v[sel];
        pkt_cnt_s  = pkt_cnt_v[sel];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic update_fifo();
        rempty  = (fifo_q.size() == 0);
        arempty = (fifo_q.size() <= 1);
        rdata   = rempty ? '0 : fifo_q[0];
    endtask

    // Write one word into the FIFO model and record what the stream must
    // deliver for it.
    task automatic applyStimulus(input logic [DW-1:0] d);
        exp_t e;
        fifo_q.push_back(d);
        e.data = d;
        e.last = (exp_idx == cur_len - 1);
        exp_q.push_back(e);
        exp_idx = (exp_idx + 1) % cur_len;
        update_fifo();
    endtask

    // One read clock: observe at the falling edge, then apply the FIFO pop
    // and any ready toggle just after the rising edge.
    task automatic tick();
        bit pop;
        @(negedge rclk);
        pop = rinc_s;
        if (rinc_s) begin
            rinc_cnt++;
            checkOutput("rinc_while_empty", rempty, 0);
        end
        if (prev_stall) checkOutput("valid_hold", m_valid_s, 1);
        hs_seen = 1'b0;
        if (m_valid_s) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_word: got 0x%0h, expected none", m_data_s);
            end else begin
                checkOutput("data", m_data_s, exp_q[0].data);
                checkOutput("last", m_last_s, exp_q[0].last);
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    hs_seen = 1'b1;
                    hs_data = m_data_s;
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                end
            end
        end
        prev_stall = m_valid_s && !m_ready;
        cyc++;
        @(posedge rclk);
        #1;
        if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        update_fifo();
        if (toggle) m_ready = ~m_ready;
    endtask

    // One-cycle reset of the selected instance; the FIFO is reset with it.
    task automatic do_reset();
        rrst_v = 3'b111;
        fifo_q.delete();
        exp_q.delete();
        exp_idx    = 0;
        prev_stall = 1'b0;
        update_fifo();
        @(posedge rclk);
        #1;
        rrst_v = ~(3'b001 << sel);
        first_hs = -1;
        last_hs  = -1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: table-driven stream vectors, then the multi-cycle
    // corner cases (en drop mid-packet, burst wait, reset mid-packet).
    initial begin
        bit found;

        sel = 2'd0; rrst_v = 3'b111; en = 1'b0; m_ready = 1'b0; toggle = 1'b0;
        cur_len = 16; exp_idx = 0; rinc_cnt = 0; cyc = 0; prev_stall = 1'b0;
        first_hs = -1; last_hs = -1; hs_seen = 1'b0; hs_data = '0;
        update_fifo();
        repeat (2) @(posedge rclk);
        #1;

        vecs[0] = '{sel: 2'd0, nwords: 32, toggle: 1'b0, base: 32'h00,  exp_words: 32, exp_pkts: 2, check_rate: 1'b1};
        vecs[1] = '{sel: 2'd0, nwords: 32, toggle: 1'b1, base: 32'h00,  exp_words: 32, exp_pkts: 2, check_rate: 1'b0};
        vecs[2] = '{sel: 2'd2, nwords: 3,  toggle: 1'b0, base: 32'h50,  exp_words: 3,  exp_pkts: 3, check_rate: 1'b1};
        vecs[3] = '{sel: 2'd0, nwords: 20, toggle: 1'b0, base: 32'h100, exp_words: 20, exp_pkts: 1, check_rate: 1'b1};
        vecs[4] = '{sel: 2'd1, nwords: 6,  toggle: 1'b0, base: 32'h200, exp_words: 6,  exp_pkts: 0, check_rate: 1'b1};

        for (int i = 0; i < 5; i++) begin
            sel     = vecs[i].sel;
            cur_len = (vecs[i].sel == 2'd2) ? 1 : 16;
            toggle  = 1'b0;
            en      = 1'b1;
            m_ready = 1'b1;
            do_reset();
            checkOutput("reset_valid", m_valid_s, 0);
            checkOutput("reset_word_cnt", word_cnt_s, 0);
            checkOutput("reset_pkt_cnt", pkt_cnt_s, 0);
            for (int k = 0; k < vecs[i].nwords; k++) applyStimulus(vecs[i].base + DW'(k));
            toggle = vecs[i].toggle;
            drain("vec_drain", 300);
            toggle = 1'b0;
            m_ready = 1'b1;
            checkOutput("vec_word_cnt", word_cnt_s, vecs[i].exp_words);
            checkOutput("vec_pkt_cnt", pkt_cnt_s, vecs[i].exp_pkts);
            if (vecs[i].check_rate) checkOutput("vec_rate", last_hs - first_hs, vecs[i].nwords - 1);
            repeat (3) tick();
            checkOutput("vec_idle_valid", m_valid_s, 0);
        end

        // en dropped after 0x05: the packet finishes at 0x0F, then nothing
        // more is popped until en returns.
        sel = 2'd0; cur_len = 16; en = 1'b1; m_ready = 1'b1; toggle = 1'b0;
        do_reset();
        for (int k = 0; k < 32; k++) applyStimulus(DW'(k));
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            tick();
            if (hs_seen && hs_data == 32'h05) found = 1'b1;
        end
        checkOutput("endrop_w05_seen", found, 1);
        en = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            tick();
            if (hs_seen && hs_data == 32'h0F) found = 1'b1;
        end
        checkOutput("endrop_w0f_seen", found, 1);
        rinc_cnt = 0;
        repeat (8) tick();
        checkOutput("endrop_no_rinc", rinc_cnt, 0);
        checkOutput("endrop_fifo_level", fifo_q.size(), 16);
        checkOutput("endrop_fifo_head", rdata, 32'h10);
        checkOutput("endrop_valid", m_valid_s, 0);
        checkOutput("endrop_word_cnt", word_cnt_s, 16);
        checkOutput("endrop_pkt_cnt", pkt_cnt_s, 1);
        en = 1'b1;
        drain("endrop_resume_drain", 200);
        checkOutput("endrop_final_words", word_cnt_s, 32);
        checkOutput("endrop_final_pkts", pkt_cnt_s, 2);

        // Burst wait: a single word must not start a transfer.
        sel = 2'd1; cur_len = 16; en = 1'b1; m_ready = 1'b1;
        do_reset();
        applyStimulus(32'h300);
        rinc_cnt = 0;
        repeat (6) tick();
        checkOutput("wb_single_no_rinc", rinc_cnt, 0);
        checkOutput("wb_single_valid", m_valid_s, 0);
        applyStimulus(32'h301);
        drain("wb_pair_drain", 50);
        checkOutput("wb_word_cnt", word_cnt_s, 2);

        // Reset mid-packet with the skid buffer full.
        sel = 2'd0; cur_len = 16; en = 1'b1; m_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 8; k++) applyStimulus(32'h400 + DW'(k));
        repeat (3) tick();
        m_ready = 1'b0;
        repeat (4) tick();
        checkOutput("rst_pre_valid", m_valid_s, 1);
        checkOutput("rst_pre_cnt_nonzero", word_cnt_s != '0, 1);
        do_reset();
        checkOutput("rst_post_valid", m_valid_s, 0);
        checkOutput("rst_post_last", m_last_s, 0);
        checkOutput("rst_post_data", m_data_s, 0);
        checkOutput("rst_post_word_cnt", word_cnt_s, 0);
        checkOutput("rst_post_pkt_cnt", pkt_cnt_s, 0);
        m_ready = 1'b1;
        for (int k = 0; k < 20; k++) applyStimulus(32'h500 + DW'(k));
        drain("rst_restart_drain", 200);
        checkOutput("rst_restart_words", word_cnt_s, 20);
        checkOutput("rst_restart_pkts", pkt_cnt_s, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
